// File: rtl/vend_txn_ctrl_if.sv
// ---------------------------------------------------------------------------
// vend_txn_ctrl_if
//   Bundles the keypad/coin front-end, the product dispenser handshake and
//   the change dispenser handshake of the vending transaction sequencer.
//
//   Front end -> controller : sel_valid, sel_product[1:0], coin_valid,
//                             coin_val[1:0], cancel
//   Controller -> front end : coin_reject, credit[4:0], timeout, busy
//   Product dispenser       : vend_valid/vend_product[1:0] out, vend_ready in
//   Change dispenser        : chg_valid out, chg_ready in
//
//   master : the environment driving the controller (front end + dispensers)
//   slave  : the controller itself
// ---------------------------------------------------------------------------
interface vend_txn_ctrl_if;
    logic       sel_valid;
    logic [1:0] sel_product;
    logic       coin_valid;
    logic [1:0] coin_val;
    logic       cancel;
    logic       coin_reject;
    logic [4:0] credit;
    logic       vend_valid;
    logic [1:0] vend_product;
    logic       vend_ready;
    logic       chg_valid;
    logic       chg_ready;
    logic       timeout;
    logic       busy;

    modport master (
        output sel_valid, sel_product, coin_valid, coin_val, cancel,
               vend_ready, chg_ready,
        input  coin_reject, credit, vend_valid, vend_product, chg_valid,
               timeout, busy
    );

    modport slave (
        input  sel_valid, sel_product, coin_valid, coin_val, cancel,
               vend_ready, chg_ready,
        output coin_reject, credit, vend_valid, vend_product, chg_valid,
               timeout, busy
    );
endinterface

// File: rtl/vend_txn_ctrl.sv
// ---------------------------------------------------------------------------
// vend_txn_ctrl
//   Transaction sequencer for the vending datapath. Latches a product
//   selection, accumulates 5/10-unit coins, requests a vend once credit
//   covers the price, then pays change back one 5-unit coin at a time.
//   A cancel or an inactivity timeout in COLLECT refunds the whole credit.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (all state and outputs to 0)
//   bus    : vend_txn_ctrl_if.slave
//            in : sel_valid, sel_product, coin_valid, coin_val, cancel,
//                 vend_ready, chg_ready
//            out: coin_reject, credit, vend_valid, vend_product, chg_valid,
//                 timeout, busy (all registered)
// ---------------------------------------------------------------------------
module vend_txn_ctrl #(
    parameter int unsigned PRICE0      = 5,
    parameter int unsigned PRICE1      = 10,
    parameter int unsigned PRICE2      = 15,
    parameter int unsigned PRICE3      = 20,
    parameter int unsigned MAX_CREDIT  = 30,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input logic            clk,
    input logic            rst_n,
    vend_txn_ctrl_if.slave bus
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [4:0]       credit_q, credit_d;
    logic [4:0]       remaining_q, remaining_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       product_q, product_d;

    logic             coin_reject_q, coin_reject_d;
    logic             vend_valid_q, vend_valid_d;
    logic             chg_valid_q, chg_valid_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;

    // Coin code to value; illegal codes map to 0 so they can never be accepted.
    function automatic logic [4:0] coin_units(input logic [1:0] code);
        case (code)
            2'b01:   return 5'd5;
            2'b10:   return 5'd10;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [4:0] price_of(input logic [1:0] prod);
        case (prod)
            2'd0:    return 5'(PRICE0);
            2'd1:    return 5'(PRICE1);
            2'd2:    return 5'(PRICE2);
            default: return 5'(PRICE3);
        endcase
    endfunction

    logic [4:0] coin_amt;
    logic [5:0] credit_sum;   // one extra bit so the ceiling check cannot wrap
    logic [4:0] price;
    logic       coin_accept;
    logic       timer_expire;
    logic       vend_hs;
    logic       chg_hs;

    assign coin_amt    = coin_units(bus.coin_val);
    assign credit_sum  = {1'b0, credit_q} + {1'b0, coin_amt};
    assign price       = price_of(product_q);

    // Cancel has priority over a coin offered in the same cycle.
    assign coin_accept = (state_q == S_COLLECT) && bus.coin_valid &&
                         (coin_amt != 5'd0) && !bus.cancel &&
                         (credit_sum <= 6'(MAX_CREDIT));

    // Fires on the TIMEOUT_CYC-th consecutive COLLECT cycle without an
    // accepted coin; cancel in that same cycle takes the refund path silently.
    assign timer_expire = (state_q == S_COLLECT) && !bus.cancel && !coin_accept &&
                          (timer_q == TMR_W'(TIMEOUT_CYC - 1));

    assign vend_hs = vend_valid_q && bus.vend_ready;
    assign chg_hs  = chg_valid_q && bus.chg_ready;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            remaining_q   <= '0;
            timer_q       <= '0;
            product_q     <= '0;
            coin_reject_q <= 1'b0;
            vend_valid_q  <= 1'b0;
            chg_valid_q   <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            remaining_q   <= remaining_d;
            timer_q       <= timer_d;
            product_q     <= product_d;
            coin_reject_q <= coin_reject_d;
            vend_valid_q  <= vend_valid_d;
            chg_valid_q   <= chg_valid_d;
            timeout_q     <= timeout_d;
            busy_q        <= busy_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        product_d   = product_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.sel_valid) begin
                    product_d = bus.sel_product;
                    credit_d  = '0;
                    timer_d   = '0;
                    state_d   = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (bus.cancel || timer_expire) begin
                    remaining_d = credit_q;
                    credit_d    = '0;
                    timer_d     = '0;
                    state_d     = (credit_q != 5'd0) ? S_CHANGE : S_IDLE;
                end else if (coin_accept) begin
                    credit_d = credit_sum[4:0];
                    timer_d  = '0;
                    if (credit_sum >= {1'b0, price}) begin
                        state_d = S_VEND;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            S_VEND: begin
                if (vend_hs) begin
                    remaining_d = credit_q - price;
                    credit_d    = '0;
                    state_d     = (credit_q != price) ? S_CHANGE : S_IDLE;
                end
            end

            S_CHANGE: begin
                if (chg_hs) begin
                    remaining_d = remaining_q - 5'd5;
                    if (remaining_q == 5'd5) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs follow the state being entered, so vend_valid and
    // chg_valid drop in the same edge that completes their final handshake.
    always_comb begin
        coin_reject_d = bus.coin_valid && !coin_accept;
        vend_valid_d  = (state_d == S_VEND);
        chg_valid_d   = (state_d == S_CHANGE);
        timeout_d     = timer_expire;
        busy_d        = (state_d != S_IDLE);
    end

    assign bus.coin_reject  = coin_reject_q;
    assign bus.credit       = credit_q;
    assign bus.vend_valid   = vend_valid_q;
    assign bus.vend_product = product_q;
    assign bus.chg_valid    = chg_valid_q;
    assign bus.timeout      = timeout_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vend_txn_ctrl
//   Directed bench for vend_txn_ctrl with default parameters
//   (prices 5/10/15/20, MAX_CREDIT 30, TIMEOUT_CYC 255).
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_vend_txn_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    vend_txn_ctrl_if bus_if ();

    vend_txn_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic select(input logic [1:0] p);
        bus_if.sel_valid   = 1'b1;
        bus_if.sel_product = p;
        tick();
        bus_if.sel_valid   = 1'b0;
    endtask

    task automatic coin(input logic [1:0] code);
        bus_if.coin_valid = 1'b1;
        bus_if.coin_val   = code;
        tick();
        bus_if.coin_valid = 1'b0;
        bus_if.coin_val   = 2'b00;
    endtask

    int  n;
    logic seen;

    initial begin
        bus_if.sel_valid   = 1'b0;
        bus_if.sel_product = 2'd0;
        bus_if.coin_valid  = 1'b0;
        bus_if.coin_val    = 2'b00;
        bus_if.cancel      = 1'b0;
        bus_if.vend_ready  = 1'b0;
        bus_if.chg_ready   = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("rst_credit", bus_if.credit, 0);
        check_eq("rst_busy", bus_if.busy, 0);
        check_eq("rst_vend_valid", bus_if.vend_valid, 0);
        check_eq("rst_chg_valid", bus_if.chg_valid, 0);
        check_eq("rst_coin_reject", bus_if.coin_reject, 0);
        check_eq("rst_timeout", bus_if.timeout, 0);
        rst_n = 1'b1;
        tick();

        // T1: product 2 (15); coins 10 then 5, exact payment
        select(2'd2);
        check_eq("t1_busy", bus_if.busy, 1);
        coin(2'b10);
        check_eq("t1_credit10", bus_if.credit, 10);
        check_eq("t1_no_vend_yet", bus_if.vend_valid, 0);
        coin(2'b01);
        check_eq("t1_credit15", bus_if.credit, 15);
        check_eq("t1_vend_valid", bus_if.vend_valid, 1);
        check_eq("t1_vend_product", bus_if.vend_product, 2);
        tick();
        check_eq("t1_vend_held", bus_if.vend_valid, 1);
        bus_if.vend_ready = 1'b1;
        tick();
        bus_if.vend_ready = 1'b0;
        check_eq("t1_vend_drop", bus_if.vend_valid, 0);
        check_eq("t1_no_change", bus_if.chg_valid, 0);
        check_eq("t1_idle", bus_if.busy, 0);
        check_eq("t1_credit0", bus_if.credit, 0);

        // T2: product 0 (5); coin 10 -> one change coin, stalled 3 cycles
        select(2'd0);
        coin(2'b10);
        check_eq("t2_vend_valid", bus_if.vend_valid, 1);
        check_eq("t2_vend_product", bus_if.vend_product, 0);
        bus_if.vend_ready = 1'b1;
        tick();
        bus_if.vend_ready = 1'b0;
        check_eq("t2_vend_drop", bus_if.vend_valid, 0);
        check_eq("t2_chg_valid", bus_if.chg_valid, 1);
        check_eq("t2_credit0", bus_if.credit, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t2_chg_stall", bus_if.chg_valid, 1);
        end
        bus_if.chg_ready = 1'b1;
        tick();
        bus_if.chg_ready = 1'b0;
        check_eq("t2_chg_done", bus_if.chg_valid, 0);
        check_eq("t2_idle", bus_if.busy, 0);

        // T3: product 3 (20); coins 10, 5; cancel with a coin in the same cycle
        select(2'd3);
        coin(2'b10);
        coin(2'b01);
        check_eq("t3_credit15", bus_if.credit, 15);
        bus_if.cancel     = 1'b1;
        bus_if.coin_valid = 1'b1;
        bus_if.coin_val   = 2'b01;
        tick();
        bus_if.cancel     = 1'b0;
        bus_if.coin_valid = 1'b0;
        check_eq("t3_cancel_reject", bus_if.coin_reject, 1);
        check_eq("t3_credit0", bus_if.credit, 0);
        check_eq("t3_chg_valid", bus_if.chg_valid, 1);
        check_eq("t3_no_timeout", bus_if.timeout, 0);
        check_eq("t3_no_vend", bus_if.vend_valid, 0);
        bus_if.chg_ready = 1'b1;
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && bus_if.chg_valid; i++) begin
            tick();
            n++;
            if (bus_if.timeout) seen = 1'b1;
        end
        bus_if.chg_ready = 1'b0;
        check_eq("t3_coins", n, 3);
        check_eq("t3_chg_end", bus_if.chg_valid, 0);
        check_eq("t3_timeout_quiet", seen, 0);
        check_eq("t3_idle", bus_if.busy, 0);

        // T4: product 1; coin 5; then idle until the inactivity refund
        select(2'd1);
        coin(2'b01);
        check_eq("t4_credit5", bus_if.credit, 5);
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            n++;
            if (bus_if.timeout) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("t4_timeout_seen", seen, 1);
        check_eq("t4_timeout_cycles", n, 255);
        check_eq("t4_credit0", bus_if.credit, 0);
        check_eq("t4_chg_valid", bus_if.chg_valid, 1);
        tick();
        check_eq("t4_timeout_pulse", bus_if.timeout, 0);
        bus_if.chg_ready = 1'b1;
        tick();
        bus_if.chg_ready = 1'b0;
        check_eq("t4_chg_done", bus_if.chg_valid, 0);
        check_eq("t4_idle", bus_if.busy, 0);

        // T5: rejected coins in IDLE, illegal code, VEND and CHANGE
        coin(2'b10);
        check_eq("t5_idle_reject", bus_if.coin_reject, 1);
        check_eq("t5_idle_credit", bus_if.credit, 0);
        check_eq("t5_idle_busy", bus_if.busy, 0);
        tick();
        check_eq("t5_reject_pulse", bus_if.coin_reject, 0);
        select(2'd0);
        coin(2'b11);
        check_eq("t5_bad_code_reject", bus_if.coin_reject, 1);
        check_eq("t5_bad_code_credit", bus_if.credit, 0);
        coin(2'b10);
        check_eq("t5_good_no_reject", bus_if.coin_reject, 0);
        check_eq("t5_credit10", bus_if.credit, 10);
        check_eq("t5_vend_valid", bus_if.vend_valid, 1);
        coin(2'b01);
        check_eq("t5_vend_reject", bus_if.coin_reject, 1);
        check_eq("t5_vend_credit", bus_if.credit, 10);
        check_eq("t5_vend_still", bus_if.vend_valid, 1);
        bus_if.vend_ready = 1'b1;
        tick();
        bus_if.vend_ready = 1'b0;
        check_eq("t5_chg_valid", bus_if.chg_valid, 1);
        coin(2'b01);
        check_eq("t5_chg_reject", bus_if.coin_reject, 1);
        check_eq("t5_chg_credit", bus_if.credit, 0);
        check_eq("t5_chg_still", bus_if.chg_valid, 1);
        bus_if.chg_ready = 1'b1;
        tick();
        bus_if.chg_ready = 1'b0;
        check_eq("t5_chg_done", bus_if.chg_valid, 0);
        check_eq("t5_idle", bus_if.busy, 0);

        // T6: asynchronous reset during CHANGE with 10 units outstanding
        select(2'd3);
        coin(2'b10);
        bus_if.cancel = 1'b1;
        tick();
        bus_if.cancel = 1'b0;
        check_eq("t6_chg_valid", bus_if.chg_valid, 1);
        check_eq("t6_busy", bus_if.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_chg_valid", bus_if.chg_valid, 0);
        check_eq("t6_rst_busy", bus_if.busy, 0);
        check_eq("t6_rst_credit", bus_if.credit, 0);
        tick();
        rst_n = 1'b1;
        bus_if.chg_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus_if.chg_valid) n++;
        end
        bus_if.chg_ready = 1'b0;
        check_eq("t6_no_more_coins", n, 0);
        check_eq("t6_idle", bus_if.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
